sdram_port_arbiter: RTL and testbench

Shares the single command port of the SoC's SDRAM controller between two requesters: port 0 (instruction fetch) and port 1 (data/load-store). It also injects periodic auto-refresh commands. It sits between the CPU bus bridges and the SDRAM controller that drives the externalSdram* pins. Only one transaction is outstanding at a time; read data is routed back to the port that issued the read.

---
 rtl/sdram_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-port SDRAM command arbiter with periodic auto-refresh injection.
// Allows one outstanding transaction at a time. Read data is returned
// to the port that issued the read.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W         = 22,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned REFRESH_PERIOD = 780
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 reqValid,
    input  logic [1:0]                 reqWrite,
    input  logic [2*ADDR_W-1:0]        reqAddress,
    input  logic [2*DATA_W-1:0]        reqWriteData,
    input  logic [2*(DATA_W/8)-1:0]    reqByteEnable,
    output logic [1:0]                 reqReady,
    output logic [1:0]                 respValid,
    output logic [DATA_W-1:0]          respData,
    output logic                       cmdValid,
    input  logic                       cmdReady,
    output logic                       cmdRefresh,
    output logic                       cmdWrite,
    output logic [ADDR_W-1:0]          cmdAddress,
    output logic [DATA_W-1:0]          cmdWriteData,
    output logic [DATA_W/8-1:0]        cmdByteEnable,
    input  logic                       rdValid,
    input  logic [DATA_W-1:0]          rdData,
    output logic                       refreshOverrun
);

    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned TIMER_W = $clog2(REFRESH_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_REFRESH   = 2'd2,
        S_WAIT_READ = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                cmd_refresh_q, cmd_refresh_d;
    logic                cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [BE_W-1:0]     cmd_be_q, cmd_be_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;

    logic                expire;
    logic                refresh_accept;
    logic                grant_port;
    logic [1:0]          owner_onehot;

    // Refresh interval timer, pending flag and sticky overrun flag
    always_comb begin
        expire         = (timer_q == '0);
        refresh_accept = (state_q == S_REFRESH) && cmdReady;
        timer_d        = expire ? TIMER_W'(REFRESH_PERIOD - 1) : timer_q - TIMER_W'(1);
        pending_d      = pending_q;
        if (expire) begin
            pending_d = 1'b1;
        end else if (refresh_accept) begin
            pending_d = 1'b0;
        end
        // A refresh being accepted in the same cycle is not an overrun
        overrun_d = overrun_q | (expire & pending_q & ~refresh_accept);
    end

    // Owner choice: a lone requester wins, a tie goes to the port not granted last
    always_comb begin
        grant_port = 1'b0;
        case (reqValid)
            2'b01:   grant_port = 1'b0;
            2'b10:   grant_port = 1'b1;
            2'b11:   grant_port = ~last_grant_q;
            default: grant_port = 1'b0;
        endcase
    end

    // Next-state and command register logic
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_refresh_d = cmd_refresh_q;
        cmd_write_d   = cmd_write_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_wdata_d   = cmd_wdata_q;
        cmd_be_d      = cmd_be_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d       = S_REFRESH;
                    cmd_valid_d   = 1'b1;
                    cmd_refresh_d = 1'b1;
                end else if (|reqValid) begin
                    state_d       = S_ISSUE;
                    owner_d       = grant_port;
                    last_grant_d  = grant_port;
                    cmd_valid_d   = 1'b1;
                    cmd_refresh_d = 1'b0;
                    cmd_write_d   = grant_port ? reqWrite[1] : reqWrite[0];
                    cmd_addr_d    = grant_port ? reqAddress[2*ADDR_W-1:ADDR_W]
                                               : reqAddress[ADDR_W-1:0];
                    cmd_wdata_d   = grant_port ? reqWriteData[2*DATA_W-1:DATA_W]
                                               : reqWriteData[DATA_W-1:0];
                    cmd_be_d      = grant_port ? reqByteEnable[2*BE_W-1:BE_W]
                                               : reqByteEnable[BE_W-1:0];
                end
            end
            S_ISSUE: begin
                if (cmdReady) begin
                    cmd_valid_d = 1'b0;
                    state_d     = cmd_write_q ? S_IDLE : S_WAIT_READ;
                end
            end
            S_REFRESH: begin
                if (cmdReady) begin
                    cmd_valid_d   = 1'b0;
                    cmd_refresh_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            S_WAIT_READ: begin
                if (rdValid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, command and refresh registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            cmd_valid_q   <= 1'b0;
            cmd_refresh_q <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= '0;
            cmd_be_q      <= '0;
            timer_q       <= TIMER_W'(REFRESH_PERIOD - 1);
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_refresh_q <= cmd_refresh_d;
            cmd_write_q   <= cmd_write_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            cmd_be_q      <= cmd_be_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
        end
    end

    // Same-cycle handshake and read-return routing to the owning port
    always_comb begin
        owner_onehot = owner_q ? 2'b10 : 2'b01;
        reqReady     = ((state_q == S_ISSUE) && cmdReady) ? owner_onehot : 2'b00;
        respValid    = ((state_q == S_WAIT_READ) && rdValid) ? owner_onehot : 2'b00;
        respData     = rdData;
    end

    assign cmdValid       = cmd_valid_q;
    assign cmdRefresh     = cmd_refresh_q;
    assign cmdWrite       = cmd_write_q;
    assign cmdAddress     = cmd_addr_q;
    assign cmdWriteData   = cmd_wdata_q;
    assign cmdByteEnable  = cmd_be_q;
    assign refreshOverrun = overrun_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: table of port transactions, scoreboarded
// command and response streams, and hand-written refresh/reset sequences.
module tb_sdram_port_arbiter;

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;
    localparam int unsigned RP     = 16;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [1:0]              reqValid = '0;
    logic [1:0]              reqWrite = '0;
    logic [2*ADDR_W-1:0]     reqAddress = '0;
    logic [2*DATA_W-1:0]     reqWriteData = '0;
    logic [2*BE_W-1:0]       reqByteEnable = '0;
    logic [1:0]              reqReady;
    logic [1:0]              respValid;
    logic [DATA_W-1:0]       respData;
    logic                    cmdValid;
    logic                    cmdReady = 1'b1;
    logic                    cmdRefresh;
    logic                    cmdWrite;
    logic [ADDR_W-1:0]       cmdAddress;
    logic [DATA_W-1:0]       cmdWriteData;
    logic [BE_W-1:0]         cmdByteEnable;
    logic                    rdValid = 1'b0;
    logic [DATA_W-1:0]       rdData = '0;
    logic                    refreshOverrun;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REFRESH_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAddress(reqAddress),
        .reqWriteData(reqWriteData), .reqByteEnable(reqByteEnable),
        .reqReady(reqReady), .respValid(respValid), .respData(respData),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdRefresh(cmdRefresh),
        .cmdWrite(cmdWrite), .cmdAddress(cmdAddress), .cmdWriteData(cmdWriteData),
        .cmdByteEnable(cmdByteEnable), .rdValid(rdValid), .rdData(rdData),
        .refreshOverrun(refreshOverrun)
    );

    typedef struct {
        logic              port;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] rdata;
    } vec_t;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } cmd_t;

    typedef struct {
        logic              port;
        logic [DATA_W-1:0] data;
    } resp_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    cmd_t  exp_cmd_q[$];
    resp_t exp_resp_q[$];
    logic  exp_last = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SDRAM controller model: byte-enabled memory, reads return 3 cycles after acceptance
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    int                rd_cnt = 0;
    logic [DATA_W-1:0] rd_next = '0;

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'hDEAD ^ a[15:0];
    endfunction

    always @(posedge clk) begin
        logic              acc, wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd, old;
        logic [BE_W-1:0]   be;
        acc = cmdValid && cmdReady && !cmdRefresh;
        wr  = cmdWrite;
        a   = cmdAddress;
        wd  = cmdWriteData;
        be  = cmdByteEnable;
        #1;
        rdValid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                rdValid = 1'b1;
                rdData  = rd_next;
            end
        end
        if (acc) begin
            if (wr) begin
                old    = mem_rd(a);
                mem[a] = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
            end else begin
                rd_cnt  = 3;
                rd_next = mem_rd(a);
            end
        end
    end

    // Clock edges seen since reset release; refresh interval expiries fall on multiples of RP
    int rel_cnt = 0;
    always @(posedge clk) begin
        if (!reset) rel_cnt = 0;
        else        rel_cnt++;
    end

    // Output monitor: command/response scoreboards, pulse width, refresh priority
    bit         owed = 1'b0;
    int         grants_owed = 0;
    int         refresh_cnt = 0;
    logic [1:0] rr_prev = '0;

    always @(negedge clk) begin
        cmd_t  c;
        resp_t r;
        if (!reset) begin
            rr_prev = '0;
            owed    = 1'b0;
        end else begin
            if (rel_cnt > 0 && (rel_cnt % RP) == 0 && !owed) begin
                owed        = 1'b1;
                grants_owed = 0;
            end
            if (cmdValid && cmdReady) begin
                if (cmdRefresh) begin
                    refresh_cnt++;
                    owed = 1'b0;
                end else if (exp_cmd_q.size() == 0) begin
                    check("unexpected_cmd", 64'(cmdAddress), 64'hFFFF_FFFF);
                end else begin
                    c = exp_cmd_q.pop_front();
                    check("cmd_fields", {23'd0, cmdWrite, cmdAddress, cmdWriteData, cmdByteEnable},
                          {23'd0, c.wr, c.addr, c.wdata, c.be});
                end
            end
            if (|reqReady) begin
                check("reqReady_pulse", 64'(reqReady & rr_prev), 64'd0);
                if (owed) begin
                    grants_owed++;
                    check("grants_before_refresh", 64'(grants_owed <= 1), 64'd1);
                end
            end
            if (|respValid) begin
                if (exp_resp_q.size() == 0) begin
                    check("unexpected_resp", 64'(respValid), 64'd0);
                end else begin
                    r = exp_resp_q.pop_front();
                    check("resp", {46'd0, respValid, respData},
                          {46'd0, (r.port ? 2'b10 : 2'b01), r.data});
                end
            end
            rr_prev = reqReady;
        end
    end

    task automatic set_port(input logic p, input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
        int pi;
        pi = int'(p);
        reqWrite[pi]                         = wr;
        reqAddress[pi*ADDR_W +: ADDR_W]      = addr;
        reqWriteData[pi*DATA_W +: DATA_W]    = wd;
        reqByteEnable[pi*BE_W +: BE_W]       = be;
        reqValid[pi]                         = 1'b1;
    endtask

    task automatic wait_ready(input logic p);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (reqReady[p]) got = 1'b1;
        end
        check("reqReady_seen", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        reqValid[p] = 1'b0;
    endtask

    task automatic do_req(input vec_t v, input bit expect_resp);
        cmd_t  c;
        resp_t r;
        c = '{v.wr, v.addr, v.wdata, v.be};
        exp_cmd_q.push_back(c);
        exp_last = v.port;
        if (!v.wr && expect_resp) begin
            r = '{v.port, v.rdata};
            exp_resp_q.push_back(r);
        end
        set_port(v.port, v.wr, v.addr, v.wdata, v.be);
        wait_ready(v.port);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (exp_resp_q.size() != 0 || exp_cmd_q.size() != 0); k++)
            @(negedge clk);
        check("drain", 64'(exp_resp_q.size() + exp_cmd_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[9];
        vec_t       v;
        cmd_t       c;
        logic [1:0] g;
        logic       start, p;
        int         idx[2];
        int         ref_before;
        bit         seen_valid, held, saw_rd;

        vecs[0] = '{1'b0, 1'b0, 22'h012345, 16'h0000, 2'b11, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 22'h000100, 16'h1234, 2'b11, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 22'h000100, 16'h0000, 2'b11, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 22'h3FFFFF, 16'hA5A5, 2'b11, 16'h0000};
        vecs[4] = '{1'b1, 1'b1, 22'h3FFFFF, 16'hFF00, 2'b10, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 22'h3FFFFF, 16'h0000, 2'b11, 16'hFFA5};
        vecs[6] = '{1'b1, 1'b0, 22'h000000, 16'h0000, 2'b11, 16'hDEAD};
        vecs[7] = '{1'b0, 1'b1, 22'h2AAAAA, 16'h00FF, 2'b01, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 22'h2AAAAA, 16'h0000, 2'b11, 16'h74FF};
        mem[22'h012345] = 16'hBEEF;

        // Reset held with both ports requesting: everything stays at reset values
        set_port(1'b0, 1'b1, 22'h000001, 16'h1111, 2'b11);
        set_port(1'b1, 1'b1, 22'h000002, 16'h2222, 2'b11);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("reset_outputs",
                  64'({cmdValid, cmdRefresh, cmdWrite, reqReady, respValid, refreshOverrun,
                       cmdAddress, cmdWriteData, cmdByteEnable}), 64'd0);
        end
        c = '{1'b1, 22'h000001, 16'h1111, 2'b11};
        exp_cmd_q.push_back(c);
        c = '{1'b1, 22'h000002, 16'h2222, 2'b11};
        exp_cmd_q.push_back(c);
        exp_last = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        g = '0;
        for (int k = 0; k < 20 && g == 2'b00; k++) begin
            @(negedge clk);
            g = reqReady;
        end
        check("first_grant", 64'(g), 64'(2'b01));
        @(posedge clk);
        #1 reqValid[0] = 1'b0;
        wait_ready(1'b1);

        // Table-driven single-port transactions
        for (int i = 0; i < 9; i++) do_req(vecs[i], 1'b1);
        drain();

        // Contention: both ports hold write requests continuously
        start = ~exp_last;
        for (int i = 0; i < 6; i++) begin
            p = start ^ 1'(i);
            c = '{1'b1, (p ? 22'h000300 : 22'h000200) + 22'(i / 2),
                  (p ? 16'hD000 : 16'hC000) + 16'(i / 2), 2'b11};
            exp_cmd_q.push_back(c);
            exp_last = p;
        end
        idx[0] = 0;
        idx[1] = 0;
        set_port(1'b0, 1'b1, 22'h000200, 16'hC000, 2'b11);
        set_port(1'b1, 1'b1, 22'h000300, 16'hD000, 2'b11);
        for (int i = 0; i < 6; i++) begin
            g = '0;
            for (int k = 0; k < 50 && g == 2'b00; k++) begin
                @(negedge clk);
                g = reqReady;
            end
            p = start ^ 1'(i);
            check("contention_grant", 64'(g), 64'(p ? 2'b10 : 2'b01));
            @(posedge clk);
            #1;
            for (int q = 0; q < 2; q++) begin
                if (g[q]) begin
                    idx[q]++;
                    if (idx[q] < 3)
                        set_port(1'(q), 1'b1, (q == 1 ? 22'h000300 : 22'h000200) + 22'(idx[q]),
                                 (q == 1 ? 16'hD000 : 16'hC000) + 16'(idx[q]), 2'b11);
                    else
                        reqValid[q] = 1'b0;
                end
            end
        end
        reqValid = '0;
        drain();

        // Refresh priority: port 1 requests back to back across several intervals
        ref_before = refresh_cnt;
        for (int i = 0; i < 20; i++) begin
            v = '{1'b1, 1'b1, 22'h000400 + 22'(i), 16'h4000 + 16'(i), 2'b11, 16'h0000};
            do_req(v, 1'b0);
        end
        drain();
        check("refreshes_during_traffic", 64'((refresh_cnt - ref_before) >= 2), 64'd1);
        check("no_overrun_under_traffic", 64'(refreshOverrun), 64'd0);

        // Overrun: controller stalls across two refresh intervals
        @(posedge clk);
        #1 cmdReady = 1'b0;
        seen_valid = 1'b0;
        held       = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (seen_valid && !(cmdValid && cmdRefresh)) held = 1'b0;
            if (cmdValid && cmdRefresh) seen_valid = 1'b1;
        end
        check("stall_cmd_held", 64'({seen_valid, held}), 64'(2'b11));
        check("stall_cmd", 64'({cmdValid, cmdRefresh}), 64'(2'b11));
        check("overrun_set", 64'(refreshOverrun), 64'd1);
        @(posedge clk);
        #1 cmdReady = 1'b1;
        repeat (10) @(negedge clk);
        check("overrun_sticky", 64'(refreshOverrun), 64'd1);

        // Reset while waiting for read data: the late return must be dropped
        v = '{1'b0, 1'b0, 22'h000777, 16'h0000, 2'b11, 16'h0000};
        do_req(v, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_outputs", 64'({cmdValid, refreshOverrun, respValid}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_last = 1'b1;
        saw_rd   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rdValid) saw_rd = 1'b1;
        end
        check("stale_rd_returned", 64'(saw_rd), 64'd1);
        check("idle_after_reset", 64'({cmdValid, reqReady, respValid}), 64'd0);
        do_req(vecs[2], 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
